// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the per-thread LSU lanes, the arbiter and the shared data-memory channel.
// Valid/ready: a requester holds valid (and its address/data) until the matching ready is seen high at a clock edge.
interface data_mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 12,
    parameter int DATA_BITS     = 16
);
    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    logic                 busy;
    logic [2:0]           dbg_state;
    logic [PTR_W-1:0]     dbg_rr_ptr;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready,
        output busy, dbg_state, dbg_rr_ptr
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready,
        input  busy, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serialising per-lane LSU read/write requests onto one data-memory port.
// Every output comes straight from a register; lane selection only feeds the grant registers.
module data_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 12,
    parameter int DATA_BITS     = 16
) (
    input logic              clk,
    input logic              reset,
    data_mem_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_READ_WAITING   = 3'd1,
        S_WRITE_WAITING  = 3'd2,
        S_READ_RELAYING  = 3'd3,
        S_WRITE_RELAYING = 3'd4
    } state_t;

    state_t                             r_state;
    logic [PTR_W-1:0]                   r_rr_ptr;
    logic [PTR_W-1:0]                   r_grant;
    logic                               r_busy;
    logic                               r_mem_read_valid;
    logic [ADDR_BITS-1:0]               r_mem_read_address;
    logic                               r_mem_write_valid;
    logic [ADDR_BITS-1:0]               r_mem_write_address;
    logic [DATA_BITS-1:0]               r_mem_write_data;
    logic [NUM_CONSUMERS-1:0]           r_read_ready;
    logic [NUM_CONSUMERS-1:0]           r_write_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data;

    logic             w_found;
    logic [PTR_W-1:0] w_sel;
    logic             w_sel_read;
    logic [PTR_W-1:0] w_next_ptr;
    int               w_idx;

    // Scan from the farthest lane back to rr_ptr so the nearest requester is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_CONSUMERS;
            if (bus.consumer_read_valid[w_idx] || bus.consumer_write_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(w_idx);
            end
        end
        w_sel_read = bus.consumer_read_valid[w_sel];
    end

    assign w_next_ptr = (int'(r_grant) == NUM_CONSUMERS - 1) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_rr_ptr            <= '0;
            r_grant             <= '0;
            r_busy              <= 1'b0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_read_ready        <= '0;
            r_write_ready       <= '0;
            r_read_data         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_busy  <= 1'b1;
                        if (w_sel_read) begin
                            r_mem_read_valid   <= 1'b1;
                            r_mem_read_address <= bus.consumer_read_address[w_sel*ADDR_BITS +: ADDR_BITS];
                            r_state            <= S_READ_WAITING;
                        end else begin
                            r_mem_write_valid   <= 1'b1;
                            r_mem_write_address <= bus.consumer_write_address[w_sel*ADDR_BITS +: ADDR_BITS];
                            r_mem_write_data    <= bus.consumer_write_data[w_sel*DATA_BITS +: DATA_BITS];
                            r_state             <= S_WRITE_WAITING;
                        end
                    end
                end
                S_READ_WAITING: begin
                    if (bus.mem_read_ready) begin
                        r_mem_read_valid                            <= 1'b0;
                        r_read_data[r_grant*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
                        r_read_ready[r_grant]                       <= 1'b1;
                        r_state                                     <= S_READ_RELAYING;
                    end
                end
                S_WRITE_WAITING: begin
                    if (bus.mem_write_ready) begin
                        r_mem_write_valid      <= 1'b0;
                        r_write_ready[r_grant] <= 1'b1;
                        r_state                <= S_WRITE_RELAYING;
                    end
                end
                S_READ_RELAYING: begin
                    if (!bus.consumer_read_valid[r_grant]) begin
                        r_read_ready <= '0;
                        r_rr_ptr     <= w_next_ptr;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_WRITE_RELAYING: begin
                    if (!bus.consumer_write_valid[r_grant]) begin
                        r_write_ready <= '0;
                        r_rr_ptr      <= w_next_ptr;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read_valid       = r_mem_read_valid;
    assign bus.mem_read_address     = r_mem_read_address;
    assign bus.mem_write_valid      = r_mem_write_valid;
    assign bus.mem_write_address    = r_mem_write_address;
    assign bus.mem_write_data       = r_mem_write_data;
    assign bus.consumer_read_ready  = r_read_ready;
    assign bus.consumer_write_ready = r_write_ready;
    assign bus.consumer_read_data   = r_read_data;
    assign bus.busy                 = r_busy;
    assign bus.dbg_state            = r_state;
    assign bus.dbg_rr_ptr           = r_rr_ptr;
endmodule
